// File: rtl/spi_host_pkg.sv
// Shared types and default widths for the SPI memory host-side driver.
package spi_host_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
        logic              timeout;
    } spi_rsp_t;

endpackage

// File: rtl/spi_host_driver.sv
// Host-side initiator: runs one reset-gated subsystem transaction per command
// and returns its result on a valid/ready response channel, with a hang timeout.
module spi_host_driver #(
    parameter int unsigned ADDR_W         = spi_host_pkg::ADDR_W,
    parameter int unsigned DATA_W         = spi_host_pkg::DATA_W,
    parameter int unsigned GUARD_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              spi_rst,
    output logic              spi_wr,
    output logic [ADDR_W-1:0] spi_addr,
    output logic [DATA_W-1:0] spi_din,
    input  logic [DATA_W-1:0] spi_dout,
    input  logic              spi_done,
    input  logic              spi_err,
    output logic              busy
);
    import spi_host_pkg::*;

    localparam int unsigned   GW         = $clog2(GUARD_CYCLES + 1);
    localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_SAT    = TW'(TIMEOUT_CYCLES);

    state_e            state;
    state_e            state_d;
    logic [GW-1:0]     guard_cnt;
    logic [GW-1:0]     guard_d;
    logic [TW-1:0]     tmo_cnt;
    logic [TW-1:0]     tmo_d;
    logic              wr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] din_d;
    logic [DATA_W-1:0] rsp_data_d;
    logic              rsp_err_d;
    logic              rsp_tmo_d;

    // Handshake readiness depends on state only, never on cmd_valid.
    assign cmd_ready = (state == IDLE) & ~rst;
    assign busy      = (state != IDLE);

    // Next-state, counters, operand capture and response capture.
    always_comb begin
        state_d    = state;
        guard_d    = guard_cnt;
        tmo_d      = tmo_cnt;
        wr_d       = spi_wr;
        addr_d     = spi_addr;
        din_d      = spi_din;
        rsp_data_d = rsp_data;
        rsp_err_d  = rsp_err;
        rsp_tmo_d  = rsp_timeout;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    wr_d    = cmd_wr;
                    addr_d  = cmd_addr;
                    din_d   = cmd_data;
                    guard_d = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (guard_cnt >= GUARD_LAST) begin
                    tmo_d   = '0;
                    state_d = RUN;
                end else begin
                    guard_d = guard_cnt + GW'(1);
                end
            end
            RUN: begin
                if (tmo_cnt != TMO_SAT) begin
                    tmo_d = tmo_cnt + TW'(1);
                end
                // done takes priority over a timeout landing in the same cycle
                if (spi_done) begin
                    rsp_data_d = spi_wr ? '0 : spi_dout;
                    rsp_err_d  = spi_err;
                    rsp_tmo_d  = 1'b0;
                    state_d    = RESP;
                end else if (tmo_cnt >= TMO_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    rsp_tmo_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; rst aborts any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            guard_cnt   <= '0;
            tmo_cnt     <= '0;
            spi_rst     <= 1'b1;
            spi_wr      <= 1'b0;
            spi_addr    <= '0;
            spi_din     <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            guard_cnt   <= guard_d;
            tmo_cnt     <= tmo_d;
            spi_rst     <= (state_d != RUN);
            spi_wr      <= wr_d;
            spi_addr    <= addr_d;
            spi_din     <= din_d;
            rsp_valid   <= (state_d == RESP);
            rsp_data    <= rsp_data_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_tmo_d;
        end
    end

endmodule

// File: tb/tb_spi_host_driver.sv
// Bench for spi_host_driver: stub subsystem, timeline model checked every cycle,
// and directed transactions with hand-computed response and latency values.
module tb_spi_host_driver;
    import spi_host_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned G  = 2;
    localparam int unsigned T  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          spi_rst;
    logic          spi_wr;
    logic [AW-1:0] spi_addr;
    logic [DW-1:0] spi_din;
    logic [DW-1:0] spi_dout = 8'h00;
    logic          spi_done = 1'b0;
    logic          spi_err  = 1'b0;
    logic          busy;

    spi_host_driver #(
        .ADDR_W(AW), .DATA_W(DW), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .spi_rst(spi_rst), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_din(spi_din),
        .spi_dout(spi_dout), .spi_done(spi_done), .spi_err(spi_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, got, exp);
        end
    endtask

    // Stub subsystem: done after stub_delay RUN cycles; addr 0xFF reports an error.
    logic [DW-1:0] stub_mem [256];
    int stub_delay = 3;
    bit stub_hang  = 1'b0;
    bit force_done = 1'b0;
    int run_idx    = 0;

    always @(negedge clk) begin
        spi_done = 1'b0;
        spi_err  = 1'b0;
        spi_dout = 8'h77;
        if (spi_rst === 1'b0) begin
            if (!stub_hang && run_idx == stub_delay) begin
                spi_done = 1'b1;
                if (spi_addr == 8'hFF) begin
                    spi_err  = 1'b1;
                    spi_dout = 8'h3C;
                end else if (spi_wr) begin
                    stub_mem[spi_addr] = spi_din;
                end else begin
                    spi_dout = stub_mem[spi_addr];
                end
            end
            run_idx++;
        end else begin
            run_idx = 0;
        end
        if (force_done) begin
            spi_done = 1'b1;
            spi_err  = 1'b1;
            spi_dout = 8'h99;
        end
    end

    // Model: one transaction as a timeline from its accept cycle.
    // ARM = cycles 1..G after accept, RUN = next m_len cycles, then RESP until handshake.
    logic [DW-1:0] m_mem [256];
    bit       m_active = 1'b0;
    int       m_acc    = 0;
    int       m_len    = 0;
    spi_cmd_t m_cmd;
    spi_rsp_t m_rsp;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if ((cyc - m_acc) > int'(G) + m_len && rsp_ready) m_active = 1'b0;
        end else if (cmd_valid) begin
            m_active = 1'b1;
            m_acc    = cyc;
            m_cmd    = '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};
            if (stub_hang || stub_delay >= int'(T)) begin
                m_len = int'(T);
                m_rsp = '{data: 8'h00, err: 1'b1, timeout: 1'b1};
            end else begin
                m_len         = stub_delay + 1;
                m_rsp.timeout = 1'b0;
                m_rsp.err     = (cmd_addr == 8'hFF);
                if (cmd_addr == 8'hFF)  m_rsp.data = cmd_wr ? 8'h00 : 8'h3C;
                else if (cmd_wr) begin
                    m_rsp.data        = 8'h00;
                    m_mem[cmd_addr]   = cmd_data;
                end else m_rsp.data   = m_mem[cmd_addr];
            end
        end
        cyc++;
    end

    always @(negedge clk) begin : cmp
        int rel;
        bit e_run;
        bit e_resp;
        if (chk_en) begin
            rel    = cyc - m_acc;
            e_run  = m_active && rel > int'(G) && rel <= int'(G) + m_len;
            e_resp = m_active && rel > int'(G) + m_len;
            check("spi_rst",   32'(spi_rst),   32'(!e_run));
            check("rsp_valid", 32'(rsp_valid), 32'(e_resp));
            check("busy",      32'(busy),      32'(m_active));
            check("cmd_ready", 32'(cmd_ready), 32'(!m_active && !rst));
            if (m_active) begin
                check("spi_wr",   32'(spi_wr),   32'(m_cmd.wr));
                check("spi_addr", 32'(spi_addr), 32'(m_cmd.addr));
                check("spi_din",  32'(spi_din),  32'(m_cmd.data));
            end
            if (e_resp) begin
                check("rsp_data",    32'(rsp_data),    32'(m_rsp.data));
                check("rsp_err",     32'(rsp_err),     32'(m_rsp.err));
                check("rsp_timeout", 32'(rsp_timeout), 32'(m_rsp.timeout));
            end
        end
    end

    // Most recent cycle in which spi_rst fell.
    int  run_start = 0;
    logic prev_srst = 1'b1;
    always @(negedge clk) begin
        if (prev_srst === 1'b1 && spi_rst === 1'b0) run_start = cyc;
        prev_srst = spi_rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int acc);
        bit got = 1'b0;
        acc       = -1;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                acc = cyc;
            end
            tick();
        end
        cmd_valid = 1'b0;
        cmd_wr    = ~wr;
        cmd_addr  = 8'hEE;
        cmd_data  = 8'h11;
        if (!got) check("accept_wait", 32'd0, 32'd1);
    endtask

    task automatic recv(input int hold, output spi_rsp_t r, output int vcyc, output int hcyc);
        bit got = 1'b0;
        r         = '0;
        vcyc      = -1;
        hcyc      = -1;
        rsp_ready = (hold == 0);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got  = 1'b1;
                vcyc = cyc;
                r    = '{data: rsp_data, err: rsp_err, timeout: rsp_timeout};
            end else begin
                tick();
            end
        end
        if (!got) begin
            check("rsp_wait", 32'd0, 32'd1);
            rsp_ready = 1'b0;
        end else if (hold == 0) begin
            hcyc = vcyc;
            tick();
            rsp_ready = 1'b0;
        end else begin
            for (int i = 0; i < hold; i++) tick();
            rsp_ready = 1'b1;
            hcyc      = cyc;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired @cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        spi_rsp_t r;
        int acc, acc2, v, h;
        for (int i = 0; i < 256; i++) begin
            stub_mem[i] = 8'h00;
            m_mem[i]    = 8'h00;
        end
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = 8'h00;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;

        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_spi_rst",   32'(spi_rst),     32'd1);
        check("rst_spi_addr",  32'(spi_addr),    32'd0);
        check("rst_spi_din",   32'(spi_din),     32'd0);
        check("rst_rsp_data",  32'(rsp_data),    32'd0);
        check("rst_rsp_err",   32'(rsp_err),     32'd0);
        check("rst_rsp_tmo",   32'(rsp_timeout), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready),   32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Write then read back.
        stub_delay = 3;
        send(1'b1, 8'h10, 8'hA5, acc);
        recv(0, r, v, h);
        check("wr_data", 32'(r.data), 32'h00);
        check("wr_err",  32'(r.err),  32'd0);
        check("wr_tmo",  32'(r.timeout), 32'd0);
        check("accept_to_run", 32'(run_start - acc), 32'd3);
        check("accept_to_valid", 32'(v - acc), 32'd7);

        stub_delay = 0;
        send(1'b0, 8'h10, 8'h00, acc);
        recv(0, r, v, h);
        check("rd_data", 32'(r.data), 32'hA5);
        check("rd_err",  32'(r.err),  32'd0);
        check("rd_accept_to_valid", 32'(v - acc), 32'd4);

        // Subsystem error.
        stub_delay = 1;
        send(1'b0, 8'hFF, 8'h00, acc);
        recv(0, r, v, h);
        check("err_data", 32'(r.data), 32'h3C);
        check("err_err",  32'(r.err),  32'd1);
        check("err_tmo",  32'(r.timeout), 32'd0);

        // Timeout.
        stub_hang = 1'b1;
        send(1'b0, 8'h20, 8'h00, acc);
        recv(0, r, v, h);
        check("tmo_data", 32'(r.data), 32'h00);
        check("tmo_err",  32'(r.err),  32'd1);
        check("tmo_tmo",  32'(r.timeout), 32'd1);
        check("tmo_run_to_valid", 32'(v - run_start), 32'd16);
        stub_hang = 1'b0;

        // Back-pressure with a pending command.
        stub_delay = 2;
        send(1'b1, 8'h30, 8'h5A, acc);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 8'h30;
        cmd_data  = 8'h00;
        recv(20, r, v, h);
        check("bp_hold", 32'(h - v), 32'd20);
        send(1'b0, 8'h30, 8'h00, acc2);
        check("bp_accept_after_hs", 32'(acc2 - h), 32'd1);
        recv(0, r, v, h);
        check("bp_rd_data", 32'(r.data), 32'h5A);

        // Reset during RUN, then a late done, then a normal command.
        stub_hang = 1'b1;
        send(1'b0, 8'h10, 8'h00, acc);
        for (int i = 0; i < 50 && spi_rst !== 1'b0; i++) begin
            @(negedge clk);
            if (spi_rst !== 1'b0) tick();
        end
        check("mid_run_reached", 32'(spi_rst), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_spi_rst",   32'(spi_rst),   32'd1);
        check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mrst_busy",      32'(busy),      32'd0);
        tick();
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("late_done_ignored", 32'(rsp_valid), 32'd0);
        tick();
        stub_hang  = 1'b0;
        stub_delay = 3;
        send(1'b0, 8'h10, 8'h00, acc);
        recv(0, r, v, h);
        check("post_rst_data", 32'(r.data), 32'hA5);
        check("post_rst_err",  32'(r.err),  32'd0);

        // done on the last RUN cycle: done wins over timeout.
        stub_delay = int'(T) - 1;
        send(1'b0, 8'h10, 8'h00, acc);
        recv(3, r, v, h);
        check("coll_data", 32'(r.data), 32'hA5);
        check("coll_err",  32'(r.err),  32'd0);
        check("coll_tmo",  32'(r.timeout), 32'd0);
        check("coll_run_to_valid", 32'(v - run_start), 32'd16);

        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_host_driver.md
Name: spi_host_driver

Overview:
- Host-side initiator for the SPI memory subsystem top level; it is the opposite end of that subsystem's parallel host interface.
- Accepts read/write commands on a valid/ready channel and drives the subsystem's wr/addr/din.
- Releases the subsystem from reset for exactly one transaction per command, waits for done, and returns data/error on a valid/ready response channel.
- Guards against a hung transaction with a timeout.

Parameters:
- ADDR_W, 8, command/memory address width
- DATA_W, 8, data width
- GUARD_CYCLES, 2, cycles the subsystem is held in reset with stable operands before release (min 1)
- TIMEOUT_CYCLES, 1024, max RUN cycles waiting for done before abort (min 2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_data  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_data  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  subsystem err seen with done, or timeout
- rsp_timeout  out  1  transaction aborted by timeout
- spi_rst  out  1  reset to subsystem
- spi_wr  out  1  to subsystem wr
- spi_addr  out  ADDR_W  to subsystem addr
- spi_din  out  DATA_W  to subsystem din
- spi_dout  in  DATA_W  from subsystem dout
- spi_done  in  1  from subsystem done (pulse)
- spi_err  in  1  from subsystem err, valid with spi_done
- busy  out  1  state != IDLE

Behaviour:
- All state updates on posedge clk. rst is synchronous, active-high, and overrides everything, including an in-flight transaction.
- Reset values:
  - spi_rst=1, spi_wr=0, spi_addr=0, spi_din=0
  - rsp_valid=0, rsp_data=0, rsp_err=0, rsp_timeout=0
  - busy=0, state=IDLE, counters=0
- cmd_ready = (state==IDLE) & ~rst. This is combinational from state only, with no dependency on cmd_valid.
- IDLE:
  - spi_rst=1.
  - On cmd_valid & cmd_ready: register cmd_wr/cmd_addr/cmd_data onto spi_wr/spi_addr/spi_din; clear the guard counter; go to ARM.
- ARM:
  - spi_rst=1, operands stable.
  - After GUARD_CYCLES cycles in ARM, go to RUN; spi_rst=0 from the first RUN cycle.
- RUN:
  - spi_rst=0; operands held stable for the whole state; timeout counter increments each cycle.
  - If spi_done=1:
    - rsp_data = spi_wr ? 0 : spi_dout.
    - rsp_err = spi_err, rsp_timeout = 0.
    - Go to RESP.
  - Else, if the counter reaches TIMEOUT_CYCLES-1:
    - rsp_data=0, rsp_err=1, rsp_timeout=1.
    - Go to RESP.
  - spi_done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid=1, spi_rst=1 (asserted the cycle after done or timeout), response fields stable.
  - On rsp_ready: rsp_valid=0 next cycle, go to IDLE.
  - rsp_ready while rsp_valid=0 is ignored.
- spi_done or spi_err outside RUN is ignored; no response is produced.
- Latency:
  - Command accept to spi_rst deassert = 1 + GUARD_CYCLES cycles.
  - done to rsp_valid = 1 cycle.
  - Earliest next accept is the cycle after the response handshake.
- Only one command is in flight; no queuing. Back-pressure on rsp_ready stalls cmd_ready indefinitely.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1). It is cleared on entry to RUN, and it saturates rather than wrapping.

Decomposition:
- Package spi_host_pkg:
  - state enum {IDLE, ARM, RUN, RESP}
  - packed struct spi_cmd_t {wr, addr, data}
  - packed struct spi_rsp_t {data, err, timeout}
  - default width localparams ADDR_W=8, DATA_W=8
- No sub-module. The guard and timeout counters are inline in the FSM block.

Test Plan:
- Write then read: cmd {wr=1, addr=0x10, data=0xA5}, then cmd {wr=0, addr=0x10}. Expect:
  - first rsp: data=0x00, err=0, timeout=0;
  - second rsp: data=0xA5, err=0;
  - spi_addr/spi_din stable through every ARM and RUN cycle;
  - spi_rst low only in RUN.
- Subsystem error: stub asserts spi_done=1, spi_err=1 on a read of addr=0xFF. Expect rsp err=1, timeout=0, data = stub dout (e.g. 0x3C).
- Timeout: stub never asserts done, TIMEOUT_CYCLES=16. Expect:
  - rsp_valid exactly 16 cycles after RUN entry;
  - rsp err=1, timeout=1, data=0;
  - spi_rst=1 on the next cycle.
- Back-pressure: hold rsp_ready=0 for 20 cycles after rsp_valid. Expect:
  - rsp fields stable;
  - cmd_ready=0 throughout;
  - a pending cmd is accepted only the cycle after the handshake.
- Reset mid-RUN: assert rst for 1 cycle during RUN. Expect:
  - next cycle IDLE, spi_rst=1, rsp_valid=0, busy=0;
  - a late spi_done is ignored;
  - a new command then completes normally.
- Same-cycle done and timeout: done on cycle TIMEOUT_CYCLES-1 of RUN. Expect timeout=0, with data and err taken from the subsystem.
